// File: rtl/nanov_shifter_serial.sv
// Sequential shift/rotate unit: captures operand and shift amount on start, then
// streams the result LSB-first, BPC bits per chunk, under a valid/ready handshake.
module nanov_shifter_serial #(
  parameter int WIDTH = 32,
  parameter int BPC = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  output logic               busy,
  output logic [BPC-1:0]     d,
  output logic               d_valid,
  input  logic               d_ready,
  output logic               done
);

  localparam int NCHUNK = WIDTH / BPC;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   a_q;
  logic [SHAMT_W-1:0] b_q;
  logic [3:0]         op_q;

  logic [SHAMT_W-1:0] idx;
  logic [SHAMT_W:0]   sum;
  logic [SHAMT_W:0]   diff;

  assign d_valid = (state == STREAM);
  assign busy    = d_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      done  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            k     <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (d_ready) begin
            if (k == K_LAST) begin
              k     <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The extra top bit of sum/diff is the carry/borrow that selects fill vs. wrap;
  // since WIDTH is a power of two, the low bits are already the modulo index.
  always_comb begin
    d    = '0;
    idx  = '0;
    sum  = '0;
    diff = '0;
    if (state == STREAM) begin
      for (int unsigned j = 0; j < BPC; j++) begin
        idx  = SHAMT_W'(32'(k) * BPC + j);
        sum  = {1'b0, idx} + {1'b0, b_q};
        diff = {1'b0, idx} - {1'b0, b_q};
        if (op_q[1]) begin
          d[j] = op_q[2] ? a_q[sum[SHAMT_W-1:0]] : a_q[diff[SHAMT_W-1:0]];
        end else if (op_q[2]) begin
          d[j] = sum[SHAMT_W] ? (op_q[3] & a_q[WIDTH-1]) : a_q[sum[SHAMT_W-1:0]];
        end else begin
          d[j] = diff[SHAMT_W] ? 1'b0 : a_q[diff[SHAMT_W-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_nanov_shifter_serial.sv
// Directed bench for nanov_shifter_serial: BPC=4 main build plus BPC=1 and BPC=32 builds.
module tb_nanov_shifter_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b0;
  logic        ready_s = 1'b1;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [4:0]  b = '0;
  int          sel = 0;

  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        dv0, dv1, dv2;
  logic        done0, done1, done2;
  logic [3:0]  d0;
  logic [0:0]  d1;
  logic [31:0] d2;

  logic        dv_s, done_s, busy_s;
  logic [31:0] d_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start0 = start_s && (sel == 0);
  assign start1 = start_s && (sel == 1);
  assign start2 = start_s && (sel == 2);

  nanov_shifter_serial #(.WIDTH(32), .BPC(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b),
    .busy(busy0), .d(d0), .d_valid(dv0), .d_ready(ready_s), .done(done0));

  nanov_shifter_serial #(.WIDTH(32), .BPC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .d(d1), .d_valid(dv1), .d_ready(ready_s), .done(done1));

  nanov_shifter_serial #(.WIDTH(32), .BPC(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op(op), .a(a), .b(b),
    .busy(busy2), .d(d2), .d_valid(dv2), .d_ready(ready_s), .done(done2));

  always_comb begin
    dv_s = dv0; done_s = done0; busy_s = busy0; d_s = {28'b0, d0};
    if (sel == 1) begin
      dv_s = dv1; done_s = done1; busy_s = busy1; d_s = {31'b0, d1};
    end else if (sel == 2) begin
      dv_s = dv2; done_s = done2; busy_s = busy2; d_s = d2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run(input int sel_i, input logic [3:0] op_i, input logic [31:0] a_i,
                     input logic [4:0] b_i, input logic [31:0] exp, input int stall_at,
                     input int stall_n, input int poke, input int exp_cyc, input string name);
    int cyc, chunk, stalled, stable, w, nch, poked;
    logic [31:0] res, held;
    sel = sel_i;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; start_s = 1'b1; ready_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 1; chunk = 0; stalled = 0; stable = 1; poked = 0; res = '0; held = '0;
    w = (sel_i == 0) ? 4 : (sel_i == 1) ? 1 : 32;
    nch = 32 / w;
    while (chunk < nch && cyc < 200) begin
      start_s = 1'b0;
      if (poke != 0 && chunk == 3 && poked == 0) begin
        start_s = 1'b1; a = ~a_i; b = b_i + 5'd3; op = 4'b0011; poked = 1;
      end
      if (!dv_s) begin
        ready_s = 1'b1;
      end else if (chunk == stall_at && stalled < stall_n) begin
        if (stalled == 0) held = d_s;
        else if (d_s !== held) stable = 0;
        stalled++;
        ready_s = 1'b0;
      end else begin
        if (chunk == stall_at && stall_n > 0 && d_s !== held) stable = 0;
        ready_s = 1'b1;
        for (int j = 0; j < w; j++) res[chunk * w + j] = d_s[j];
        chunk++;
      end
      @(negedge clk);
      cyc++;
    end
    start_s = 1'b0;
    ready_s = 1'b1;
    chk({name, " chunks"}, chunk, nch);
    chk({name, " result"}, res, exp);
    chk({name, " done_cycle"}, cyc, exp_cyc);
    chk({name, " done"}, {31'b0, done_s}, 32'd1);
    chk({name, " busy_at_done"}, {31'b0, busy_s}, 32'd0);
    if (stall_n > 0) chk({name, " stall_stable"}, stable, 1);
    @(negedge clk);
    chk({name, " done_pulse"}, {31'b0, done_s}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int nd;
    vecs.push_back('{4'b0001, 32'h8000_0001, 5'd4,  32'h0000_0010, "sll4"});
    vecs.push_back('{4'b1101, 32'h8000_00F0, 5'd4,  32'hF800_000F, "sra4"});
    vecs.push_back('{4'b0101, 32'h8000_00F0, 5'd4,  32'h0800_000F, "srl4"});
    vecs.push_back('{4'b0111, 32'h0000_00F1, 5'd4,  32'h1000_000F, "ror4"});
    vecs.push_back('{4'b0011, 32'h8000_0001, 5'd1,  32'h0000_0003, "rol1"});
    vecs.push_back('{4'b0001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sll0"});
    vecs.push_back('{4'b0101, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "srl0"});
    vecs.push_back('{4'b1101, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sra0"});
    vecs.push_back('{4'b0011, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "rol0"});
    vecs.push_back('{4'b0111, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "ror0"});
    vecs.push_back('{4'b0001, 32'h0000_0003, 5'd31, 32'h8000_0000, "sll31"});
    vecs.push_back('{4'b1101, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31"});
    vecs.push_back('{4'b1101, 32'h7000_0000, 5'd4,  32'h0700_0000, "sra_pos"});
    vecs.push_back('{4'b0100, 32'hF000_0000, 5'd31, 32'h0000_0001, "srl_op0"});
    vecs.push_back('{4'b1110, 32'h0000_0001, 5'd1,  32'h8000_0000, "rot_prec"});
    vecs.push_back('{4'b0011, 32'h1234_5678, 5'd8,  32'h3456_7812, "rol8"});
    vecs.push_back('{4'b0111, 32'h1234_5678, 5'd8,  32'h7812_3456, "ror8"});

    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, busy0}, 32'd0);
    chk("rst d_valid", {31'b0, dv0}, 32'd0);
    chk("rst d", {28'b0, d0}, 32'd0);
    chk("rst done", {31'b0, done0}, 32'd0);
    chk("rst d_valid_bpc1", {31'b0, dv1}, 32'd0);
    chk("rst d_valid_bpc32", {31'b0, dv2}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, -1, 0, 0, 9, vecs[i].name);

    run(0, 4'b0001, 32'h8000_0001, 5'd4, 32'h0000_0010, 2, 3, 0, 12, "stall");
    run(0, 4'b1101, 32'h8000_00F0, 5'd4, 32'hF800_000F, -1, 0, 1, 9, "start_ignored");

    // Abort mid-stream: reset lands while chunk 5 is on the bus.
    sel = 0;
    @(negedge clk);
    op = 4'b0001; a = 32'h8000_0001; b = 5'd4; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst d_valid", {31'b0, dv0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst d_valid", {31'b0, dv0}, 32'd0);
    chk("async_rst busy", {31'b0, busy0}, 32'd0);
    chk("async_rst d", {28'b0, d0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || dv0) nd++;
    end
    chk("rst no_done", nd, 0);
    run(0, 4'b0111, 32'h0000_00F1, 5'd4, 32'h1000_000F, -1, 0, 0, 9, "post_rst");

    run(1, 4'b0101, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, -1, 0, 0, 33, "bpc1_srl");
    run(2, 4'b0101, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, -1, 0, 0, 2, "bpc32_srl");
    run(2, 4'b0011, 32'h8000_0001, 5'd1, 32'h0000_0003, -1, 0, 0, 2, "bpc32_rol");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
